mvm_backward: RTL and testbench
===============================

# mvm_backward

Transposed-direction matrix-vector multiplier for the backpropagation datapath.
- Forward pass: the layer's `mvm` computes the output from a length-MATRIX_HEIGHT activation vector.
- This block computes `result[r] = sum_c matrix[r][c] * vector[c]`, taking a length-MATRIX_WIDTH error vector back to a length-MATRIX_HEIGHT error vector.
- It uses the same weight matrix packing as the forward block, without a transpose.
- Fixed-point, tiled, multi-cycle, with a start/valid handshake.

## Interface
- MATRIX_WIDTH, 4, columns; length of input vector
- MATRIX_HEIGHT, 5, rows; length of result vector
- VECTOR_CELL_WIDTH, 8, signed vector cell bits
- MATRIX_CELL_WIDTH, 8, signed matrix cell bits
- RESULT_CELL_WIDTH, 8, signed result cell bits
- FRACTION_WIDTH, 4, fraction bits of vector and matrix cells
- TILING_ROW, 3, parallel row lanes
- TILING_COL, 3, multipliers per lane
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- vector  in  MATRIX_WIDTH*VECTOR_CELL_WIDTH  cell c at [c*VECTOR_CELL_WIDTH +: VECTOR_CELL_WIDTH]
- matrix  in  MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH  cell (r,c) at [(r*MATRIX_WIDTH+c)*MATRIX_CELL_WIDTH +: MATRIX_CELL_WIDTH]
- result  out  MATRIX_HEIGHT*RESULT_CELL_WIDTH  cell r at [r*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH]
- valid  out  1  result complete; level
- error  out  1  at least one result cell overflowed; level
- busy  out  1  high in RUN

## Operation
- States: IDLE, RUN.
- **IDLE, start=1:**
  - Latch vector and matrix into internal registers; inputs may change afterwards.
  - Clear result, valid and error.
  - Set row=0 and col=0, clear the lane accumulators, then enter RUN.
- **RUN:**
  - Lane i handles row row+i.
  - On each cycle, each lane adds products for columns col..col+TILING_COL-1, then col advances by TILING_COL.
  - A column ≥ MATRIX_WIDTH contributes 0. A row ≥ MATRIX_HEIGHT is computed but never written.
- **Writeback:** when col has reached ceil(MATRIX_WIDTH/TILING_COL) steps, the next cycle is writeback.
  - Each valid lane writes `acc >>> FRACTION_WIDTH`, narrowed to RESULT_CELL_WIDTH, into result[row+i].
  - Accumulators clear, row advances by TILING_ROW, and col resets to 0.
- **Completion:** writeback of the last group (row+TILING_ROW ≥ MATRIX_HEIGHT) sets valid=1 and returns to IDLE.
- **Arithmetic:**
  - Products are signed, full width VECTOR_CELL_WIDTH+MATRIX_CELL_WIDTH.
  - Accumulators are signed, with ceil(log2(MATRIX_WIDTH))+1 extra guard bits; no accumulator overflow is possible.
- **Overflow:** a shifted sum outside the signed RESULT_CELL_WIDTH range sets error. error is sticky until the next accepted start.
- **start outside IDLE** is ignored.
- **start in IDLE while valid=1** is accepted; valid and error drop on that same edge.
- **Reset:** rst low at any time, including mid-operation, immediately forces state=IDLE, result=0, valid=0, error=0, busy=0, counters=0 and accumulators=0.

## Timing
- Let K = ceil(MATRIX_WIDTH/TILING_COL) and G = ceil(MATRIX_HEIGHT/TILING_ROW).
- The edge that samples start is edge 0.
- Group g accumulates on edges g*(K+1)+1 .. g*(K+1)+K and writes back on edge (g+1)*(K+1).
- valid rises on edge G*(K+1). Defaults: K=2, G=2, so edge 6.
- busy is high from edge 0 until edge G*(K+1).
- result cells update only on writeback edges and are stable while valid=1.
- If start is held high continuously, valid is high for exactly one cycle before the next run begins.

## Configuration
- MVM_BACKWARD_SATURATE_EN defined: an overflowing cell clamps to the signed max or min of RESULT_CELL_WIDTH.
- Undefined: an overflowing cell takes the low RESULT_CELL_WIDTH bits of the shifted sum (wraps).
- error behaviour is identical in both cases.

## Structure
- Shared package/include holds:
  - log2 and ceil_div functions
  - IDLE/RUN state encoding
  - Accumulator width calculation (shared with `mvm`)
- Sub-module `mvm_backward_lane` holds one row lane:
  - TILING_COL signed multipliers with column masking
  - The accumulator with clear/enable
  - The shift and narrow/saturate output stage
  - Instantiated TILING_ROW times.

## Test plan
- **Positive sum:** defaults; all matrix=16, all vector=16 (1.0), start → valid at edge 6; each of 5 result cells=0x40, error=0.
- **Sign handling:** matrix=16, vector=-16 (0xF0) → each result=0xC0 (-4.0), error=0.
- **Overflow:** matrix=127, vector=127 → sum 64516>>4=4032.
  - With the macro: each cell 0x7F, error=1.
  - Without the macro: each cell 0xC0, error=1.
- **Input latching and ignored start:**
  - Change vector to 0 on edge 1 after start → results unchanged from the first scenario.
  - Pulse start on edge 3 → ignored, valid still at edge 6.
  - start held high → valid high for one cycle, then cleared on restart.
- **Reset mid-run:** assert rst low between edges 3 and 4 → result, valid, error, busy all 0 immediately; no valid until a new start, and that run completes at its own edge 6.

Source files
------------

// File: rtl/mvm_backward_pkg.sv
// rtl/mvm_backward_pkg.sv - shared sizing helpers and state encoding for mvm_backward
// Accumulator width helper is common with the forward mvm block.
package mvm_backward_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int log2_ceil(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Full product width plus guard bits so summing n products never overflows.
    function automatic int acc_width(input int vec_w, input int mat_w, input int n);
        return vec_w + mat_w + log2_ceil(n) + 1;
    endfunction

endpackage

// File: rtl/mvm_backward_lane.sv
// rtl/mvm_backward_lane.sv - one row lane: masked multipliers, accumulator, shift/narrow stage
// MVM_BACKWARD_SATURATE_EN selects clamping instead of wrapping on overflow.
module mvm_backward_lane
    import mvm_backward_pkg::*;
#(
    parameter int MATRIX_WIDTH      = 4,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int TILING_COL        = 3,
    parameter int STEP_W            = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic                                      clr_i,
    input  logic                                      en_i,
    input  logic [STEP_W-1:0]                         step_i,
    input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0] vector_i,
    input  logic [MATRIX_WIDTH*MATRIX_CELL_WIDTH-1:0] row_i,
    output logic [RESULT_CELL_WIDTH-1:0]              result_o,
    output logic                                      ovf_o
);

    localparam int V = VECTOR_CELL_WIDTH;
    localparam int M = MATRIX_CELL_WIDTH;
    localparam int R = RESULT_CELL_WIDTH;
    localparam int P = V + M;
    localparam int A = acc_width(V, M, MATRIX_WIDTH);
    localparam logic signed [A-1:0] RMAX = A'(2 ** (R - 1) - 1);
    localparam logic signed [A-1:0] RMIN = ~RMAX;

    logic signed [A-1:0] acc_q, acc_d, shifted;
    logic signed [P-1:0] prod;
    int                  col;

    always_comb begin
        acc_d = acc_q;
        prod  = '0;
        col   = 0;
        for (int t = 0; t < TILING_COL; t++) begin
            col = int'(step_i) * TILING_COL + t;
            if (col < MATRIX_WIDTH) begin
                prod  = $signed(vector_i[col*V +: V]) * $signed(row_i[col*M +: M]);
                acc_d = acc_d + A'(prod);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign shifted = acc_q >>> FRACTION_WIDTH;
    assign ovf_o   = (shifted > RMAX) || (shifted < RMIN);

`ifdef MVM_BACKWARD_SATURATE_EN
    always_comb begin
        if (shifted > RMAX)      result_o = RMAX[R-1:0];
        else if (shifted < RMIN) result_o = RMIN[R-1:0];
        else                     result_o = shifted[R-1:0];
    end
`else
    assign result_o = shifted[R-1:0];
`endif

endmodule

// File: rtl/mvm_backward.sv
// rtl/mvm_backward.sv - tiled fixed-point result[r] = sum_c matrix[r][c]*vector[c], start/valid handshake
// MVM_BACKWARD_SATURATE_EN (in the lane) clamps overflowing cells; default wraps.
module mvm_backward
    import mvm_backward_pkg::*;
#(
    parameter int MATRIX_WIDTH      = 4,
    parameter int MATRIX_HEIGHT     = 5,
    parameter int VECTOR_CELL_WIDTH = 8,
    parameter int MATRIX_CELL_WIDTH = 8,
    parameter int RESULT_CELL_WIDTH = 8,
    parameter int FRACTION_WIDTH    = 4,
    parameter int TILING_ROW        = 3,
    parameter int TILING_COL        = 3
) (
    input  logic                                                    clk_i,
    input  logic                                                    rst_n_i,
    input  logic                                                    start_i,
    input  logic [MATRIX_WIDTH*VECTOR_CELL_WIDTH-1:0]               vector_i,
    input  logic [MATRIX_WIDTH*MATRIX_HEIGHT*MATRIX_CELL_WIDTH-1:0] matrix_i,
    output logic [MATRIX_HEIGHT*RESULT_CELL_WIDTH-1:0]              result_o,
    output logic                                                    valid_o,
    output logic                                                    error_o,
    output logic                                                    busy_o
);

    localparam int W      = MATRIX_WIDTH;
    localparam int H      = MATRIX_HEIGHT;
    localparam int R      = RESULT_CELL_WIDTH;
    localparam int ROWW   = MATRIX_WIDTH * MATRIX_CELL_WIDTH;
    localparam int K      = ceil_div(W, TILING_COL);
    localparam int STEP_W = log2_ceil(K + 1) + 1;
    localparam int ROW_W  = log2_ceil(H + TILING_ROW) + 1;

    state_e                                    state_q;
    logic [STEP_W-1:0]                         step_q;
    logic [ROW_W-1:0]                          row_q;
    logic [W*VECTOR_CELL_WIDTH-1:0]            vec_q;
    logic [W*H*MATRIX_CELL_WIDTH-1:0]          mat_q;
    logic [H*R-1:0]                            result_q;
    logic                                      valid_q;
    logic                                      error_q;

    logic                                      acc_clr;
    logic                                      acc_en;
    logic                                      wb;
    logic [ROWW-1:0]                           lane_row [TILING_ROW];
    logic [R-1:0]                              lane_res [TILING_ROW];
    logic                                      lane_ovf [TILING_ROW];

    // Step K of each group is the writeback cycle rather than a multiply step.
    assign wb      = (state_q == RUN) && (step_q == STEP_W'(K));
    assign acc_en  = (state_q == RUN) && (step_q != STEP_W'(K));
    assign acc_clr = ((state_q == IDLE) && start_i) || wb;

    always_comb begin
        for (int i = 0; i < TILING_ROW; i++) begin
            lane_row[i] = (int'(row_q) + i < H) ? mat_q[(int'(row_q) + i)*ROWW +: ROWW] : '0;
        end
    end

    for (genvar i = 0; i < TILING_ROW; i++) begin : g_lane
        mvm_backward_lane #(
            .MATRIX_WIDTH     (MATRIX_WIDTH),
            .VECTOR_CELL_WIDTH(VECTOR_CELL_WIDTH),
            .MATRIX_CELL_WIDTH(MATRIX_CELL_WIDTH),
            .RESULT_CELL_WIDTH(RESULT_CELL_WIDTH),
            .FRACTION_WIDTH   (FRACTION_WIDTH),
            .TILING_COL       (TILING_COL),
            .STEP_W           (STEP_W)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .clr_i   (acc_clr),
            .en_i    (acc_en),
            .step_i  (step_q),
            .vector_i(vec_q),
            .row_i   (lane_row[i]),
            .result_o(lane_res[i]),
            .ovf_o   (lane_ovf[i])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            step_q   <= '0;
            row_q    <= '0;
            vec_q    <= '0;
            mat_q    <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        vec_q    <= vector_i;
                        mat_q    <= matrix_i;
                        result_q <= '0;
                        valid_q  <= 1'b0;
                        error_q  <= 1'b0;
                        step_q   <= '0;
                        row_q    <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    if (!wb) begin
                        step_q <= step_q + 1'b1;
                    end else begin
                        for (int i = 0; i < TILING_ROW; i++) begin
                            if (int'(row_q) + i < H) begin
                                result_q[(int'(row_q) + i)*R +: R] <= lane_res[i];
                                if (lane_ovf[i]) error_q <= 1'b1;
                            end
                        end
                        step_q <= '0;
                        row_q  <= row_q + ROW_W'(TILING_ROW);
                        if (int'(row_q) + TILING_ROW >= H) begin
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign result_o = result_q;
    assign valid_o  = valid_q;
    assign error_o  = error_q;
    assign busy_o   = (state_q == RUN);

endmodule

// File: tb/tb_mvm_backward.sv
// tb/tb_mvm_backward.sv - scoreboard bench for mvm_backward with directed vectors
module tb_mvm_backward;

    localparam int W = 4;
    localparam int H = 5;
    localparam int V = 8;
    localparam int M = 8;
    localparam int R = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [W*V-1:0]   vector;
    logic [W*H*M-1:0] matrix;
    logic [H*R-1:0]   result;
    logic             valid;
    logic             error;
    logic             busy;

    always #5 clk = ~clk;

    mvm_backward dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .vector_i(vector),
        .matrix_i(matrix),
        .result_o(result),
        .valid_o (valid),
        .error_o (error),
        .busy_o  (busy)
    );

    typedef struct {
        logic [H*R-1:0] res;
        logic           err;
        int             at;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid && !valid_prev) begin
            if (sbq.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sbq.pop_front();
                check("result", result, e.res);
                check("error", error, e.err);
                check("valid_edge", cyc, e.at);
            end
        end
        valid_prev = valid;
    end

    task automatic fill(input logic [7:0] m, input logic [7:0] v);
        matrix = {(W*H){m}};
        vector = {W{v}};
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!valid) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run(input logic [H*R-1:0] er, input logic ee);
        @(negedge clk);
        start = 1'b1;
        sbq.push_back('{er, ee, cyc + 7});
        @(negedge clk);
        start = 1'b0;
        check("busy_run", busy, 1);
        wait_valid();
        check("busy_done", busy, 0);
    endtask

    localparam logic [H*R-1:0] POS40 = {H{8'h40}};
    localparam logic [H*R-1:0] NEGC0 = {H{8'hC0}};
`ifdef MVM_BACKWARD_SATURATE_EN
    localparam logic [H*R-1:0] OVF_RES = {H{8'h7F}};
`else
    localparam logic [H*R-1:0] OVF_RES = {H{8'hC0}};
`endif

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        vector = '0;
        matrix = '0;
        repeat (3) @(negedge clk);
        check("reset_result", result, 0);
        check("reset_valid", valid, 0);
        check("reset_error", error, 0);
        check("reset_busy", busy, 0);
        rst_n = 1'b1;

        fill(8'd16, 8'd16);
        run(POS40, 1'b0);
        fill(8'd16, 8'hF0);
        run(NEGC0, 1'b0);
        fill(8'd127, 8'd127);
        run(OVF_RES, 1'b1);

        // Row r weights (r+1)/16, vector (1, 2, -1, 3) -> result 5*(r+1)/16
        vector = {8'h30, 8'hF0, 8'h20, 8'h10};
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                matrix[(r*W + c)*M +: M] = 8'(r + 1);
        run({8'h19, 8'h14, 8'h0F, 8'h0A, 8'h05}, 1'b0);

        // Latched inputs and a start pulse mid-run that must be ignored
        fill(8'd16, 8'd16);
        @(negedge clk);
        start = 1'b1;
        sbq.push_back('{POS40, 1'b0, cyc + 7});
        @(negedge clk);
        start  = 1'b0;
        vector = '0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_valid();
        repeat (4) @(negedge clk);
        check("ignored_start_busy", busy, 0);
        check("ignored_start_valid", valid, 1);

        // Start held high: one-cycle valid then back-to-back restart
        fill(8'd16, 8'd16);
        @(negedge clk);
        start = 1'b1;
        sbq.push_back('{POS40, 1'b0, cyc + 7});
        sbq.push_back('{POS40, 1'b0, cyc + 14});
        repeat (7) @(negedge clk);
        check("held_valid_high", valid, 1);
        @(negedge clk);
        check("held_valid_one_cycle", valid, 0);
        check("held_restart_busy", busy, 1);
        start = 1'b0;
        wait_valid();

        // Reset between edges 3 and 4, after group 0 has written back
        fill(8'd16, 8'hF0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_result", result[R-1:0], 8'hC0);
        rst_n = 1'b0;
        #1;
        check("midreset_result", result, 0);
        check("midreset_valid", valid, 0);
        check("midreset_error", error, 0);
        check("midreset_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_no_valid", valid, 0);
        fill(8'd16, 8'd16);
        run(POS40, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
